conv1d_port_arbiter: RTL
========================

# conv1d_port_arbiter

Round-robin burst arbiter sharing one conv1d datapath port among four requesters (e.g. input fetch, weight fetch, bias fetch, result write-back). Grants one requester at a time for a burst of `len+1` beats and drives the select of the downstream 4:1 word mux. It handles the per-beat valid/ready handshake between the owner and the shared port. It sits between the conv1d engine's stream sources and the shared memory/stream port.

## Interface
- `NumReq`, 4: number of requesters; fixed to 4 to match the 4:1 mux.
- `LenWidth`, 8: width of burst-length field; beats per burst = `len+1` (1..256).
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  NumReq  per-requester beat valid; a rising request also requests ownership.
- `req_len_i`  in  NumReq×LenWidth  packed burst lengths; slice i belongs to requester i; sampled only at grant.
- `gnt_o`  out  NumReq  one-hot ownership; held for the whole burst.
- `req_ready_o`  out  NumReq  per-requester beat ready; only the owner's bit can be high.
- `sel_o`  out  2  mux select = owner index (0 → din1 … 3 → din4).
- `out_valid_o`  out  1  beat valid towards the shared port.
- `out_ready_i`  in  1  shared port accepts beat.
- `out_last_o`  out  1  current beat is the last of the burst.
- `busy_o`  out  1  burst in progress.

## Operation
- States: `ARB_IDLE`, `ARB_BURST`.
- ARB_IDLE: if any `req_valid_i` is high, pick a winner by round-robin starting at `rr_ptr`, wrapping 3→0. Register owner, `sel_o`, one-hot `gnt_o`, beat counter = `req_len_i[owner]`. Go to ARB_BURST. With no request, stay.
- ARB_BURST:
  - `out_valid_o = req_valid_i[owner]`.
  - `req_ready_o[owner] = out_ready_i`; all other `req_ready_o` bits are 0.
  - `out_last_o = out_valid_o && (cnt == 0)`.
  - Beat transfers when `out_valid_o && out_ready_i`. On a transfer with cnt ≠ 0, decrement cnt.
  - On a transfer with cnt == 0: go to ARB_IDLE, clear `gnt_o`, set `rr_ptr = owner+1` (mod 4).
- Owner dropping `req_valid_i` mid-burst stalls the burst (no abort). Counter and ownership hold.
- Non-owner requests are ignored during ARB_BURST and compete at the next ARB_IDLE.
- `req_len_i` changes after grant have no effect.
- `sel_o` keeps the last owner while in ARB_IDLE; it does not return to 0.
- Counter is LenWidth bits and never underflows: exit happens at 0.

## Timing
- Reset values: state ARB_IDLE, `rr_ptr`=0, `sel_o`=0, `gnt_o`=0, cnt=0, `busy_o`=0, `out_valid_o`=0, `out_last_o`=0, `req_ready_o`=0.
- `gnt_o`, `sel_o`, `busy_o` are registered. `out_valid_o`, `out_last_o`, `req_ready_o` are combinational from state and inputs.
- Request visible in ARB_IDLE at cycle N → `gnt_o`/`busy_o` high at N+1. First beat can transfer at N+1.
- Last beat at cycle M → ARB_IDLE at M+1 → next grant at M+2. There is one mandatory bubble between bursts.
- Minimum burst occupancy is `len+1` cycles with `out_ready_i` held high.
- Reset asserted mid-burst: all outputs take reset values immediately (async). Partial burst is discarded.

## Configuration
- `CONV1D_ARB_PRIO_EN` defined: requester 0 wins every ARB_IDLE arbitration in which it requests. A burst by requester 0 does not update `rr_ptr`. Requesters 1–3 rotate round-robin among themselves.
- Not defined: pure round-robin over all four requesters, as described above.

## Structure
- Package `conv1d_arb_pkg`: `arb_state_e` enum (`ARB_IDLE`, `ARB_BURST`), `NumReq`, `SelWidth = $clog2(NumReq)`.
- Sub-module `conv1d_rr_pick`: combinational rotate-priority picker. Inputs: request vector and pointer. Outputs: winner index and found flag. The macro override sits in the parent, not in the picker.

## Test plan
- Single request: req 2 valid, len=3, `out_ready_i`=1 → grant at N+1, `sel_o`=2, 4 beats, `out_last_o` on 4th, `busy_o` low after.
- All four requesting continuously, len=0 each → grant order 0,1,2,3,0, one idle cycle between grants; with `CONV1D_ARB_PRIO_EN` the order is 0,0,0….
- Backpressure: len=2, `out_ready_i` toggles 1,0,1,0,1 → exactly 3 transfers, counter holds on stalls, `req_ready_o` follows `out_ready_i`.
- Owner drops `req_valid_i` for 5 cycles mid-burst → `out_valid_o` low, `gnt_o` held, burst resumes and completes with the correct beat count.
- Length change: `req_len_i[1]` changes from 7 to 1 after grant → 8 beats still transferred.
- Reset asserted during beat 2 of a len=5 burst → all outputs zero immediately. After release, arbitration restarts with `rr_ptr`=0.

Source files
------------

// File: rtl/conv1d_arb_pkg.sv
// Shared types and constants for the conv1d four-way burst port arbiter.
package conv1d_arb_pkg;

    localparam int unsigned NumReq   = 4;
    localparam int unsigned SelWidth = $clog2(NumReq);

    typedef enum logic {
        ARB_IDLE,
        ARB_BURST
    } arb_state_e;

endpackage

// File: rtl/conv1d_rr_pick.sv
// Combinational rotate-priority picker: first asserted request at or after ptr, wrapping.
module conv1d_rr_pick
    import conv1d_arb_pkg::*;
(
    input  logic [NumReq-1:0]   req,
    input  logic [SelWidth-1:0] ptr,
    output logic [SelWidth-1:0] winner,
    output logic                found
);

    logic [SelWidth-1:0] cand;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            // Truncation to SelWidth gives the mod-NumReq wrap.
            cand = SelWidth'(32'(ptr) + k);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/conv1d_port_arbiter.sv
// Round-robin burst arbiter for the shared conv1d port; optional fixed priority
// for requester 0 when CONV1D_ARB_PRIO_EN is defined.
module conv1d_port_arbiter
    import conv1d_arb_pkg::*;
#(
    parameter int unsigned LenWidth = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumReq-1:0]          req_valid_i,
    input  logic [NumReq*LenWidth-1:0] req_len_i,
    output logic [NumReq-1:0]          gnt_o,
    output logic [NumReq-1:0]          req_ready_o,
    output logic [SelWidth-1:0]        sel_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       out_last_o,
    output logic                       busy_o
);

    arb_state_e            state_q, state_d;
    logic [NumReq-1:0]     gnt_q, gnt_d;
    logic [SelWidth-1:0]   sel_q, sel_d;
    logic [SelWidth-1:0]   ptr_q, ptr_d;
    logic [LenWidth-1:0]   cnt_q, cnt_d;

    logic [NumReq-1:0]     pick_req;
    logic [SelWidth-1:0]   pick_idx;
    logic                  pick_found;
    logic [SelWidth-1:0]   win;
    logic                  win_found;
    logic                  xfer;

`ifdef CONV1D_ARB_PRIO_EN
    // Requester 0 bypasses the rotation; the picker only arbitrates 1..3.
    assign pick_req  = {req_valid_i[NumReq-1:1], 1'b0};
    assign win       = req_valid_i[0] ? '0 : pick_idx;
    assign win_found = |req_valid_i;
`else
    assign pick_req  = req_valid_i;
    assign win       = pick_idx;
    assign win_found = pick_found;
`endif

    conv1d_rr_pick u_pick (
        .req    (pick_req),
        .ptr    (ptr_q),
        .winner (pick_idx),
        .found  (pick_found)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        req_ready_o = '0;
        xfer        = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (win_found) begin
                    state_d = ARB_BURST;
                    sel_d   = win;
                    gnt_d   = NumReq'(1) << win;
                    cnt_d   = req_len_i[32'(win)*LenWidth +: LenWidth];
                end
            end
            ARB_BURST: begin
                out_valid_o        = req_valid_i[sel_q];
                req_ready_o[sel_q] = out_ready_i;
                out_last_o         = out_valid_o && (cnt_q == '0);
                xfer               = out_valid_o && out_ready_i;
                if (xfer) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
`ifdef CONV1D_ARB_PRIO_EN
                        if (sel_q != '0) begin
                            ptr_d = sel_q + 1'b1;
                        end
`else
                        ptr_d = sel_q + 1'b1;
`endif
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign gnt_o  = gnt_q;
    assign sel_o  = sel_q;
    assign busy_o = (state_q == ARB_BURST);

endmodule
